// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle RV32IM M-extension unit (MUL/MULH/MULHSU/MULHU,
// DIV/DIVU/REM/REMU). Radix-2 shift-add multiply and restoring divide, one
// iteration per cycle over XLEN cycles, followed by a single sign-fix cycle.
//
// Ports:
//   clk            in   rising-edge clock
//   rst_n          in   synchronous active-low reset
//   start_i        in   request, sampled only while idle
//   alu_control_i  in   5-bit op code; only the eight M codes are accepted
//   src_a_i        in   rs1 (multiplicand / dividend)
//   src_b_i        in   rs2 (multiplier / divisor)
//   flush_i        in   abort the in-flight op
//   busy_o         out  registered; high while iterating or fixing signs
//   stall_o        out  combinational; holds the pipeline until the result is ready
//   done_o         out  registered; one-cycle pulse with a valid result
//   result_o       out  registered; holds the last result until the next done
module muldiv_sequencer #(
  parameter int unsigned XLEN      = 32,
  parameter bit          EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [4:0]      alu_control_i,
  input  logic [XLEN-1:0] src_a_i,
  input  logic [XLEN-1:0] src_b_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned CW = (XLEN > 2) ? $clog2(XLEN) : 1;
  localparam int unsigned PW = 2 * XLEN;

  // M-extension op codes (alu_control encoding)
  localparam logic [4:0] ALU_MUL    = 5'd16;
  localparam logic [4:0] ALU_MULH   = 5'd17;
  localparam logic [4:0] ALU_MULHSU = 5'd18;
  localparam logic [4:0] ALU_MULHU  = 5'd19;
  localparam logic [4:0] ALU_DIV    = 5'd20;
  localparam logic [4:0] ALU_DIVU   = 5'd21;
  localparam logic [4:0] ALU_REM    = 5'd22;
  localparam logic [4:0] ALU_REMU   = 5'd23;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   prod_q, prod_d;
  logic [XLEN-1:0] a_mag_q, a_mag_d;
  logic [XLEN-1:0] b_mag_q, b_mag_d;
  logic            div_q, div_d;
  logic            hi_q, hi_d;
  logic            neg_res_q, neg_res_d;
  logic            neg_rem_q, neg_rem_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] result_q, result_d;

  // Op decode: validity, divide vs multiply, operand signedness, high/rem select
  logic op_valid, op_div, op_sa, op_sb, op_hi;

  always_comb begin
    op_valid = 1'b1;
    op_div   = 1'b0;
    op_sa    = 1'b0;
    op_sb    = 1'b0;
    op_hi    = 1'b0;
    case (alu_control_i)
      ALU_MUL:    begin op_sa = 1'b1; op_sb = 1'b1; end
      ALU_MULH:   begin op_sa = 1'b1; op_sb = 1'b1; op_hi = 1'b1; end
      ALU_MULHSU: begin op_sa = 1'b1; op_hi = 1'b1; end
      ALU_MULHU:  begin op_hi = 1'b1; end
      ALU_DIV:    begin op_div = 1'b1; op_sa = 1'b1; op_sb = 1'b1; end
      ALU_DIVU:   begin op_div = 1'b1; end
      ALU_REM:    begin op_div = 1'b1; op_sa = 1'b1; op_sb = 1'b1; op_hi = 1'b1; end
      ALU_REMU:   begin op_div = 1'b1; op_hi = 1'b1; end
      default:    op_valid = 1'b0;
    endcase
  end

  // Operand magnitudes and divide special cases at acceptance
  logic            a_neg, b_neg, b_zero, div_ovf, early;
  logic [XLEN-1:0] a_mag, b_mag, early_res;

  always_comb begin
    a_neg     = op_sa & src_a_i[XLEN-1];
    b_neg     = op_sb & src_b_i[XLEN-1];
    a_mag     = a_neg ? -src_a_i : src_a_i;
    b_mag     = b_neg ? -src_b_i : src_b_i;
    b_zero    = (src_b_i == '0);
    div_ovf   = op_div & op_sa & (src_a_i == XMIN) & (src_b_i == '1);
    early     = EARLY_OUT & op_div & (b_zero | div_ovf);
    // Overflow quotient equals the dividend (most negative value), remainder 0
    if (op_hi) early_res = b_zero ? src_a_i : '0;
    else       early_res = b_zero ? '1 : src_a_i;
  end

  // One iteration step: prod_q holds {hi, lo} = {partial product, multiplier}
  // for multiply, {remainder, dividend/quotient} for divide.
  logic [XLEN:0]   mul_sum;
  logic [PW-1:0]   mul_next;
  logic [XLEN:0]   div_shift, div_diff;
  logic            div_ok;
  logic [PW-1:0]   div_next;

  always_comb begin
    mul_sum   = {1'b0, prod_q[PW-1:XLEN]} + (prod_q[0] ? {1'b0, a_mag_q} : '0);
    mul_next  = {mul_sum, prod_q[XLEN-1:1]};
    div_shift = {prod_q[PW-1:XLEN], prod_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, b_mag_q};
    div_ok    = ~div_diff[XLEN];
    div_next  = {(div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                 prod_q[XLEN-2:0], div_ok};
  end

  // Sign correction and result selection for the FIX cycle
  logic [PW-1:0]   mul_fix;
  logic [XLEN-1:0] quo_fix, rem_fix, fix_res;

  always_comb begin
    mul_fix = neg_res_q ? -prod_q : prod_q;
    quo_fix = neg_res_q ? -prod_q[XLEN-1:0] : prod_q[XLEN-1:0];
    rem_fix = neg_rem_q ? -prod_q[PW-1:XLEN] : prod_q[PW-1:XLEN];
    if (div_q) fix_res = hi_q ? rem_fix : quo_fix;
    else       fix_res = hi_q ? mul_fix[PW-1:XLEN] : mul_fix[XLEN-1:0];
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prod_d    = prod_q;
    a_mag_d   = a_mag_q;
    b_mag_d   = b_mag_q;
    div_d     = div_q;
    hi_d      = hi_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    done_d    = 1'b0;
    result_d  = result_q;

    case (state_q)
      S_IDLE: begin
        if (start_i && op_valid && !flush_i) begin
          a_mag_d   = a_mag;
          b_mag_d   = b_mag;
          div_d     = op_div;
          hi_d      = op_hi;
          // A zero divisor never negates the quotient: it must stay all-ones
          neg_res_d = (a_neg ^ b_neg) & ~(op_div & b_zero);
          neg_rem_d = a_neg;
          cnt_d     = '0;
          prod_d    = {{XLEN{1'b0}}, (op_div ? a_mag : b_mag)};
          if (early) begin
            result_d = early_res;
            done_d   = 1'b1;
            state_d  = S_DONE;
          end else begin
            state_d  = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          prod_d = div_q ? div_next : mul_next;
          if (cnt_q == CW'(XLEN - 1)) begin
            state_d = S_FIX;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_FIX: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          result_d = fix_res;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_RUN) || (state_d == S_FIX);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      prod_q    <= '0;
      a_mag_q   <= '0;
      b_mag_q   <= '0;
      div_q     <= 1'b0;
      hi_q      <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prod_q    <= prod_d;
      a_mag_q   <= a_mag_d;
      b_mag_q   <= b_mag_d;
      div_q     <= div_d;
      hi_q      <= hi_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;
  assign stall_o  = (start_i & op_valid & (state_q == S_IDLE)) | busy_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: two instances (EARLY_OUT=1 and EARLY_OUT=0) share
// the same stimulus; results are checked against an arithmetic reference model.
module tb_muldiv_sequencer;

  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_MUL    = 5'd16;
  localparam logic [4:0] ALU_MULH   = 5'd17;
  localparam logic [4:0] ALU_MULHSU = 5'd18;
  localparam logic [4:0] ALU_MULHU  = 5'd19;
  localparam logic [4:0] ALU_DIV    = 5'd20;
  localparam logic [4:0] ALU_DIVU   = 5'd21;
  localparam logic [4:0] ALU_REM    = 5'd22;
  localparam logic [4:0] ALU_REMU   = 5'd23;
  localparam logic [31:0] XMIN      = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  alu_control;
  logic [31:0] src_a, src_b;
  logic        flush;
  logic        busy1, stall1, done1, busy0, stall0, done0;
  logic [31:0] res1, res0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.XLEN(32), .EARLY_OUT(1'b1)) dut_eo1 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .alu_control_i(alu_control),
    .src_a_i(src_a), .src_b_i(src_b), .flush_i(flush),
    .busy_o(busy1), .stall_o(stall1), .done_o(done1), .result_o(res1));

  muldiv_sequencer #(.XLEN(32), .EARLY_OUT(1'b0)) dut_eo0 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .alu_control_i(alu_control),
    .src_a_i(src_a), .src_b_i(src_b), .flush_i(flush),
    .busy_o(busy0), .stall_o(stall0), .done_o(done0), .result_o(res0));

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic plus the RISC-V divide corner rules
  function automatic logic [31:0] ref_model(input logic [4:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb, q;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    p  = '0;
    case (op)
      ALU_MUL:    begin p = 64'(sa * sb); return p[31:0]; end
      ALU_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
      ALU_MULHSU: begin p = 64'(sa * longint'(ub)); return p[63:32]; end
      ALU_MULHU:  begin p = ua * ub; return p[63:32]; end
      ALU_DIV: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == XMIN && b == 32'hFFFF_FFFF) return XMIN;
        q = sa / sb; p = 64'(q); return p[31:0];
      end
      ALU_REM: begin
        if (b == 32'h0) return a;
        if (a == XMIN && b == 32'hFFFF_FFFF) return 32'h0;
        q = sa % sb; p = 64'(q); return p[31:0];
      end
      ALU_DIVU: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      ALU_REMU: return (b == 32'h0) ? a : a % b;
      default:  return 32'h0;
    endcase
  endfunction

  function automatic bit is_special(input logic [4:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    bit is_div, signed_div;
    is_div     = (op >= ALU_DIV) && (op <= ALU_REMU);
    signed_div = (op == ALU_DIV) || (op == ALU_REM);
    return is_div && ((b == 32'h0) || (signed_div && a == XMIN && b == 32'hFFFF_FFFF));
  endfunction

  // Issue one op to both instances, then watch 36 cycles for done/latency/profile
  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string nm, input bit chk_prof);
    int lat1, lat0, nd1, nd0, bad_busy, bad_stall;
    logic [31:0] r1, r0;
    lat1 = -1; lat0 = -1; nd1 = 0; nd0 = 0; bad_busy = 0; bad_stall = 0;
    r1 = 'x; r0 = 'x;
    @(negedge clk);
    start = 1'b1; alu_control = op; src_a = a; src_b = b;
    @(posedge clk);
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start = 1'b0; src_a = $urandom; src_b = $urandom;
      end
      if (done1) begin nd1++; if (lat1 < 0) begin lat1 = k; r1 = res1; end end
      if (done0) begin nd0++; if (lat0 < 0) begin lat0 = k; r0 = res0; end end
      if (chk_prof) begin
        if (busy0 !== (k <= 32)) bad_busy++;
        if (done0 && stall0 !== 1'b0) bad_stall++;
      end
    end
    check32({nm, "_res_eo1"}, r1, exp);
    check32({nm, "_res_eo0"}, r0, exp);
    check_int({nm, "_lat_eo1"}, lat1, is_special(op, a, b) ? 0 : 33);
    check_int({nm, "_lat_eo0"}, lat0, 33);
    check_int({nm, "_ndone_eo1"}, nd1, 1);
    check_int({nm, "_ndone_eo0"}, nd0, 1);
    if (chk_prof) begin
      check_int({nm, "_busy_profile_errs"}, bad_busy, 0);
      check_int({nm, "_stall_in_done_errs"}, bad_stall, 0);
    end
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  op;
    logic [31:0] a, b;
    int          seen;
    logic [31:0] h1, h0;

    vecs[0]  = '{ALU_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[1]  = '{ALU_MULH,   XMIN,         XMIN,          32'h4000_0000};
    vecs[2]  = '{ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[3]  = '{ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[4]  = '{ALU_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
    vecs[5]  = '{ALU_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
    vecs[6]  = '{ALU_DIVU,   32'd100,      32'd7,         32'd14};
    vecs[7]  = '{ALU_REMU,   32'd100,      32'd7,         32'd2};
    vecs[8]  = '{ALU_DIVU,   32'd5,        32'd0,         32'hFFFF_FFFF};
    vecs[9]  = '{ALU_REMU,   32'd5,        32'd0,         32'd5};
    vecs[10] = '{ALU_DIV,    XMIN,         32'hFFFF_FFFF, XMIN};
    vecs[11] = '{ALU_REM,    XMIN,         32'hFFFF_FFFF, 32'h0};
    vecs[12] = '{ALU_DIV,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF};
    vecs[13] = '{ALU_REM,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB};

    rst_n = 1'b0; start = 1'b0; flush = 1'b0;
    alu_control = ALU_ADD; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("reset_busy", {busy1, busy0, stall1, stall0, done1, done0}, '0);
    check32("reset_result_eo1", res1, 32'h0);
    check32("reset_result_eo0", res0, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++)
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i), i == 0);

    for (int i = 0; i < 40; i++) begin
      op = 5'(ALU_MUL + 5'($urandom_range(0, 7)));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: begin a = XMIN; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
        3: b = 32'($signed(-int'($urandom_range(1, 20))));
        default: ;
      endcase
      do_op(op, a, b, ref_model(op, a, b), $sformatf("rnd%0d", i), 1'b0);
    end

    // Flush in the 10th RUN cycle: no done, result holds the previous value
    do_op(ALU_REMU, 32'd100, 32'd7, 32'd2, "pre_flush", 1'b0);
    @(negedge clk);
    start = 1'b1; alu_control = ALU_MUL; src_a = 32'd5; src_b = 32'd5;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    check32("flush_busy_done", {busy1, busy0, done1, done0}, '0);
    check32("flush_hold_eo1", res1, 32'd2);
    check32("flush_hold_eo0", res0, 32'd2);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done1 || done0 || busy1 || busy0) seen++;
    end
    check_int("flush_no_activity", seen, 0);
    do_op(ALU_DIV, 32'd9, 32'd3, 32'd3, "post_flush_div", 1'b0);

    // start held with changing operands during RUN: only the first op counts
    @(negedge clk);
    start = 1'b1; alu_control = ALU_MUL; src_a = 32'd3; src_b = 32'd5;
    @(posedge clk);
    seen = 0; h1 = 'x; h0 = 'x;
    for (int k = 0; k < 40 && seen == 0; k++) begin
      @(negedge clk);
      src_a = $urandom; src_b = $urandom;
      if (done0) begin seen = 1; h1 = res1; h0 = res0; start = 1'b0; end
    end
    start = 1'b0;
    check_int("hold_start_done_seen", seen, 1);
    check32("hold_start_res_eo1", h1, 32'd15);
    check32("hold_start_res_eo0", h0, 32'd15);
    repeat (3) @(negedge clk);
    check32("hold_start_no_reaccept", {busy1, busy0, done1, done0}, '0);

    // Non-M op with start: ignored
    @(negedge clk);
    start = 1'b1; alu_control = ALU_ADD; src_a = 32'd1; src_b = 32'd2;
    #1;
    check32("add_no_stall", {stall1, stall0}, '0);
    @(posedge clk);
    @(negedge clk);
    check32("add_no_busy", {busy1, busy0, done1, done0}, '0);
    start = 1'b0;

    // Reset in the middle of RUN
    @(negedge clk);
    start = 1'b1; alu_control = ALU_MUL; src_a = 32'd9; src_b = 32'd9;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check32("midrun_reset_flags", {busy1, busy0, stall1, stall0, done1, done0}, '0);
    check32("midrun_reset_res_eo1", res1, 32'h0);
    check32("midrun_reset_res_eo0", res0, 32'h0);
    rst_n = 1'b1;
    do_op(ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "post_reset_mulhu", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
